// File: rtl/cpu_run_monitor_pkg.sv
// cpu_run_monitor_pkg: shared state encoding and default parameters for the run monitor and its dump sequencer
package cpu_run_monitor_pkg;
  typedef enum logic [2:0] {IDLE, HOLD, RUN, DRAIN, RD_REQ, RD_CAP, PRESENT, DONE} state_t;
  localparam int DEF_INSTR_WIDTH = 32;
  localparam int DEF_DATA_WIDTH = 128;
  localparam int DEF_ADDR_WIDTH = 8;
  localparam int DEF_DUMP_DEPTH = 128;
  localparam int DEF_RESET_CYCLES = 5;
  localparam int DEF_DRAIN_CYCLES = 5;
  localparam int DEF_CNT_WIDTH = 32;
  localparam int DEF_MAX_CYCLES = 0;
  localparam logic [31:0] DEF_HALT_WORD = 32'h0000_0000;
endpackage

// File: rtl/cpu_run_monitor_dump.sv
// cpu_run_monitor_dump: on go, reads dmem words 0..DUMP_DEPTH-1 and presents each on a valid/ready stream; ports: clk/reset, go, mem_en/mem_addr/mem_rdata, dump_valid/dump_ready/dump_addr/dump_data, last_done
module cpu_run_monitor_dump
  import cpu_run_monitor_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DUMP_DEPTH = DEF_DUMP_DEPTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  go,
  output logic                  mem_en,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  dump_valid,
  input  logic                  dump_ready,
  output logic [ADDR_WIDTH-1:0] dump_addr,
  output logic [DATA_WIDTH-1:0] dump_data,
  output logic                  last_done
);
  state_t state_q, state_d;
  logic [ADDR_WIDTH-1:0] k_q, k_d, dump_addr_q, dump_addr_d;
  logic [DATA_WIDTH-1:0] dump_data_q, dump_data_d;
  logic mem_en_q, mem_en_d, dump_valid_q, dump_valid_d, xfer, last_k;
  always_comb begin
    xfer = state_q == PRESENT && dump_ready;
    last_k = k_q == ADDR_WIDTH'(DUMP_DEPTH - 1);
    last_done = xfer && last_k;
    state_d = go ? RD_REQ : state_q == RD_REQ ? RD_CAP : state_q == RD_CAP ? PRESENT : xfer ? (last_k ? IDLE : RD_REQ) : state_q;
    k_d = go ? '0 : (xfer && !last_k) ? k_q + ADDR_WIDTH'(1) : k_q;
    mem_en_d = state_d == RD_REQ;
    dump_valid_d = state_d == PRESENT;
    dump_addr_d = state_q == RD_CAP ? k_q : dump_addr_q;
    dump_data_d = state_q == RD_CAP ? mem_rdata : dump_data_q;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state_q <= IDLE;
      k_q <= '0;
      mem_en_q <= 1'b0;
      dump_valid_q <= 1'b0;
      dump_addr_q <= '0;
      dump_data_q <= '0;
    end else begin
      state_q <= state_d;
      k_q <= k_d;
      mem_en_q <= mem_en_d;
      dump_valid_q <= dump_valid_d;
      dump_addr_q <= dump_addr_d;
      dump_data_q <= dump_data_d;
    end
  assign mem_en = mem_en_q;
  assign mem_addr = k_q;
  assign dump_valid = dump_valid_q;
  assign dump_addr = dump_addr_q;
  assign dump_data = dump_data_q;
endmodule

// File: rtl/cpu_run_monitor.sv
// cpu_run_monitor: holds CPU reset, times the run to the halt word or watchdog, drains, then dumps dmem; ports: clk/reset, start, instruction, cpu_reset, mem_sel/mem_en/mem_addr/mem_rdata, dump_valid/dump_ready/dump_addr/dump_data, cycle_count, busy/done/timeout
module cpu_run_monitor
  import cpu_run_monitor_pkg::*;
#(
  parameter int INSTR_WIDTH = DEF_INSTR_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DUMP_DEPTH = DEF_DUMP_DEPTH,
  parameter int RESET_CYCLES = DEF_RESET_CYCLES,
  parameter int DRAIN_CYCLES = DEF_DRAIN_CYCLES,
  parameter int CNT_WIDTH = DEF_CNT_WIDTH,
  parameter int MAX_CYCLES = DEF_MAX_CYCLES,
  parameter logic [INSTR_WIDTH-1:0] HALT_WORD = DEF_HALT_WORD
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [INSTR_WIDTH-1:0] instruction,
  output logic                   cpu_reset,
  output logic                   mem_sel,
  output logic                   mem_en,
  output logic [ADDR_WIDTH-1:0]  mem_addr,
  input  logic [DATA_WIDTH-1:0]  mem_rdata,
  output logic                   dump_valid,
  input  logic                   dump_ready,
  output logic [ADDR_WIDTH-1:0]  dump_addr,
  output logic [DATA_WIDTH-1:0]  dump_data,
  output logic [CNT_WIDTH-1:0]   cycle_count,
  output logic                   busy,
  output logic                   done,
  output logic                   timeout
);
  localparam int TW = $clog2((RESET_CYCLES > DRAIN_CYCLES ? RESET_CYCLES : DRAIN_CYCLES) + 1);
  state_t state_q, state_d;
  logic [TW-1:0] tmr_q, tmr_d;
  logic [CNT_WIDTH-1:0] cyc_q, cyc_d, cyc_inc;
  logic cpu_reset_q, cpu_reset_d, mem_sel_q, mem_sel_d, busy_q, busy_d, done_q, done_d, timeout_q, timeout_d;
  logic go, last_done, halt, limit;
  always_comb begin
    halt = instruction == HALT_WORD;
    cyc_inc = &cyc_q ? cyc_q : cyc_q + CNT_WIDTH'(1);
    limit = MAX_CYCLES != 0 && cyc_inc == CNT_WIDTH'(MAX_CYCLES);
    go = state_q == DRAIN && tmr_q == '0;
    state_d = state_q;
    tmr_d = tmr_q;
    cyc_d = cyc_q;
    timeout_d = timeout_q;
    case (state_q)
      IDLE, DONE: if (start) begin
        state_d = HOLD;
        tmr_d = TW'(RESET_CYCLES - 1);
        cyc_d = '0;
        timeout_d = 1'b0;
      end
      HOLD: begin
        tmr_d = tmr_q - TW'(1);
        if (tmr_q == '0) state_d = RUN;
      end
      RUN: begin
        cyc_d = cyc_inc;
        if (halt || limit) begin
          state_d = DRAIN;
          tmr_d = TW'(DRAIN_CYCLES - 1);
          timeout_d = !halt;
        end
      end
      DRAIN: begin
        tmr_d = tmr_q - TW'(1);
        if (tmr_q == '0) state_d = RD_REQ;
      end
      RD_REQ: if (last_done) state_d = DONE;
      default: state_d = state_q;
    endcase
    cpu_reset_d = !(state_d == RUN || state_d == DRAIN);
    mem_sel_d = state_d == RD_REQ;
    busy_d = !(state_d == IDLE || state_d == DONE);
    done_d = state_d == DONE;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state_q <= IDLE;
      tmr_q <= '0;
      cyc_q <= '0;
      cpu_reset_q <= 1'b1;
      mem_sel_q <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q <= state_d;
      tmr_q <= tmr_d;
      cyc_q <= cyc_d;
      cpu_reset_q <= cpu_reset_d;
      mem_sel_q <= mem_sel_d;
      busy_q <= busy_d;
      done_q <= done_d;
      timeout_q <= timeout_d;
    end
  cpu_run_monitor_dump #(.DATA_WIDTH(DATA_WIDTH), .ADDR_WIDTH(ADDR_WIDTH), .DUMP_DEPTH(DUMP_DEPTH)) u_dump (
    .clk(clk), .reset(reset), .go(go),
    .mem_en(mem_en), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
    .dump_valid(dump_valid), .dump_ready(dump_ready), .dump_addr(dump_addr), .dump_data(dump_data),
    .last_done(last_done)
  );
  assign cpu_reset = cpu_reset_q;
  assign mem_sel = mem_sel_q;
  assign cycle_count = cyc_q;
  assign busy = busy_q;
  assign done = done_q;
  assign timeout = timeout_q;
endmodule
